mbc_rtc_chip: RTL
=================

# mbc_rtc_chip

Parametrised cartridge memory bank controller with battery-clock registers, the next generation of the team's cartridge mapper. Sits between the CPU cartridge bus and the external ROM/RAM, decodes bank-select writes, and produces banked ROM and RAM addresses and chip selects. Unlike the earlier mapper it adds a real-time clock, with seconds/minutes/hours/day counters, halt and day carry, plus a latch-on-write snapshot that the CPU reads through the RAM window. All state is clocked from one clock; CPU write strobes are edge-detected against it.

## Interface
- ROM_BANK_BITS, 7, width of the ROM bank register (up to 2^ROM_BANK_BITS × 16 KiB ROM)
- RAM_BANK_BITS, 2, width of the RAM bank field (0 < RAM_BANK_BITS ≤ 3)
- TICKS_PER_SEC, 4194304, clk cycles per RTC second (≥ 2)
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- iadr  in  16  CPU address
- data_in  in  8  CPU write data
- write  in  1  CPU write strobe, synchronous to clk, held ≥ 1 cycle
- rom_adr  out  14+ROM_BANK_BITS  external ROM address
- ram_adr  out  13+RAM_BANK_BITS  external RAM address
- sel_rom  out  1  ROM chip select
- sel_ram  out  1  RAM chip select
- data_out  out  8  RTC register read data
- data_oe  out  1  drive data_out onto the CPU bus

## Operation
- Write event: a cycle where write=1 and write was 0 in the previous cycle. It captures iadr and data_in. Register effects are visible from the next cycle. Holding write high produces one event only.
- Write decode (iadr[15:13]):
  - 000: ena ← (data_in[3:0]==4'hA).
  - 001: rom_bank ← data_in[ROM_BANK_BITS-1:0].
  - 010: bank_sel ← data_in[3:0].
  - 011: latch sequencer.
  - 101: if ena and bank_sel is an RTC index, write the live RTC field. Otherwise no internal effect, because the RAM itself takes the write via sel_ram.
- Read/select decode (combinational):
  - 0x0000–0x3FFF: sel_rom=1, rom_adr={0, iadr[13:0]}.
  - 0x4000–0x7FFF: sel_rom=1, rom_adr={eff_bank, iadr[13:0]}. eff_bank = rom_bank, except rom_bank==0 gives 1. Only all-zero is remapped; 0x20, 0x40 and 0x60 are selectable.
  - 0xA000–0xBFFF: RAM bank or RTC access, as follows:
    - bank_sel < 2^RAM_BANK_BITS: sel_ram=ena, ram_adr={bank_sel[RAM_BANK_BITS-1:0], iadr[12:0]}.
    - bank_sel 0x8–0xC: sel_ram=0, data_oe=ena & !write, data_out=latched register.
    - Any other value: nothing selected, data_oe=0.
  - All other addresses: no select. While reset=1, sel_rom=sel_ram=data_oe=0.
- RTC registers (index: field):
  - 0x8: seconds, 6 bits.
  - 0x9: minutes, 6 bits.
  - 0xA: hours, 5 bits.
  - 0xB: day[7:0].
  - 0xC: {carry, halt, 5'b0, day[8]}.
  - Unused bits read 0 and are ignored on write.
- Prescaler: counts 0..TICKS_PER_SEC-1 while halt=0 and freezes while halt=1. Wrap from TICKS_PER_SEC-1 to 0 is a tick. Writing seconds clears the prescaler.
- Tick increment, with a ripple carry within the same cycle:
  - seconds: 59→0 carries into minutes.
  - minutes: 59→0 carries into hours.
  - hours: 23→0 carries into day.
  - day: 511→0 sets carry. carry is sticky until written 0.
  - A field holding an out-of-range value (e.g. seconds=62) increments modulo 2^width (63→0) with no carry.
- Latch sequencer: states IDLE and ARMED.
  - Write 0x00 in 0x6000–0x7FFF: go to ARMED.
  - In ARMED, write 0x01: copy all live fields into the latched set, then go to IDLE.
  - Any other write value in that range: go to IDLE. Writes elsewhere do not disturb the state.
- Simultaneous tick and CPU RTC write: the tick (with carries) applies first, then the written field is overwritten by data_in.

## Timing
- Reset values:
  - ena=0, rom_bank=0 (effective bank 1), bank_sel=0.
  - Live and latched RTC fields all 0, halt=0, carry=0.
  - Prescaler 0, sequencer IDLE, write-edge history 0.
  - Outputs: sel_rom=sel_ram=data_oe=0, data_out=0. rom_adr and ram_adr follow iadr decode with bank 0/1.
- Decode outputs are combinational from iadr and registers, with zero latency.
- Register writes: edge at cycle N, new value visible at cycle N+1.
- Latch copy is visible on data_out at N+1 after the 0x01 edge.
- First tick occurs TICKS_PER_SEC cycles after reset release or after a seconds write.
- Reset asserted mid-count or mid-sequence clears everything immediately, including an ARMED sequencer.

## Test plan
- Bank mapping:
  - Write 0x00 to 0x2000, then read 0x4123: rom_adr=0x04123 (bank 1).
  - Write 0x20: rom_adr=0x80123.
  - Write 0x0A to 0x0000 and 0x03 to 0x4000, then read 0xA456: sel_ram=1, ram_adr=0x6456.
  - Write 0x00 to 0x0000: sel_ram=0.
- Write edge: hold write=1 for 5 cycles on 0x2000 with data 0x05, changing data to 0x07 on cycle 3 → rom_bank=5.
- Seconds rollover, with TICKS_PER_SEC=4:
  - Set seconds=59, minutes=59, hours=23, day=511; latch.
  - After 4 cycles, latch again: seconds=minutes=hours=day=0, carry=1 (reg 0xC reads 0x80).
- Halt and out-of-range:
  - Write 0xC=0x40 and seconds=62, then wait 20 cycles: seconds stays 62.
  - Clear halt and wait 8 cycles: seconds=0, minutes unchanged.
- Latch sequence:
  - Writes 0x00, 0x05, 0x01 to 0x6000 → no latch; latched values unchanged.
  - Writes 0x00, 0x01 → latched values update.
- Reset: assert reset while ARMED with day=300 → all outputs 0 and sequencer IDLE; a lone 0x01 write does not latch.

Source files
------------

// File: rtl/mbc_rtc_chip_if.sv
// Cartridge bus between the CPU side and the mapper.
//   master: drives iadr/data_in/write, observes the decode outputs.
//   slave : the mapper; consumes the CPU bus, drives ROM/RAM addresses,
//           chip selects and the RTC read path (data_out/data_oe).
interface mbc_rtc_chip_if #(
  parameter int ROM_BANK_BITS = 7,
  parameter int RAM_BANK_BITS = 2
);
  logic [15:0]                 iadr;
  logic [7:0]                  data_in;
  logic                        write;
  logic [14+ROM_BANK_BITS-1:0] rom_adr;
  logic [13+RAM_BANK_BITS-1:0] ram_adr;
  logic                        sel_rom;
  logic                        sel_ram;
  logic [7:0]                  data_out;
  logic                        data_oe;

  modport master (
    output iadr, data_in, write,
    input  rom_adr, ram_adr, sel_rom, sel_ram, data_out, data_oe
  );

  modport slave (
    input  iadr, data_in, write,
    output rom_adr, ram_adr, sel_rom, sel_ram, data_out, data_oe
  );
endinterface

// File: rtl/mbc_rtc_chip.sv
// Cartridge memory bank controller with real-time clock registers.
// Decodes edge-detected CPU writes into enable/bank registers, maps CPU
// addresses to banked ROM/RAM addresses, and runs a seconds/minutes/hours/
// day counter whose snapshot (latched set) is read through the RAM window.
//   clk, reset : system clock, asynchronous active-high reset
//   bus        : slave side of mbc_rtc_chip_if (CPU bus in, ROM/RAM decode
//                and RTC read data out)
module mbc_rtc_chip #(
  parameter int ROM_BANK_BITS = 7,
  parameter int RAM_BANK_BITS = 2,
  parameter int TICKS_PER_SEC = 4194304
) (
  input  logic clk,
  input  logic reset,
  mbc_rtc_chip_if.slave bus
);
  localparam int PW = $clog2(TICKS_PER_SEC);

  typedef enum logic {IDLE, ARMED} seq_t;

  logic                     write_q;
  logic                     ena;
  logic [ROM_BANK_BITS-1:0] rom_bank;
  logic [3:0]               bank_sel;
  logic [PW-1:0]            presc, presc_n;
  seq_t                     seq_state, seq_next;
  logic                     latch_now;

  // live and latched RTC fields
  logic [5:0] sec, min, sec_n, min_n, l_sec, l_min;
  logic [4:0] hr, hr_n, l_hr;
  logic [8:0] day, day_n, l_day;
  logic       halt, carry, halt_n, carry_n, l_halt, l_carry;

  logic wr_evt, tick, c_sec, c_min, c_hr, c_day;
  logic [2:0] wr_reg;

  assign wr_evt = bus.write & ~write_q;
  assign wr_reg = bus.iadr[15:13];

  // Latch sequencer: 0x00 arms from any state; 0x01 while armed copies.
  always_comb begin
    seq_next  = seq_state;
    latch_now = 1'b0;
    if (wr_evt && wr_reg == 3'b011) begin
      if (bus.data_in == 8'h00) begin
        seq_next = ARMED;
      end else if (seq_state == ARMED && bus.data_in == 8'h01) begin
        latch_now = 1'b1;
        seq_next  = IDLE;
      end else begin
        seq_next = IDLE;
      end
    end
  end

  // Tick with same-cycle ripple carry, then a CPU field write overrides.
  always_comb begin
    tick  = !halt && (presc == PW'(TICKS_PER_SEC - 1));
    c_sec = tick  && (sec == 6'd59);
    c_min = c_sec && (min == 6'd59);
    c_hr  = c_min && (hr  == 5'd23);
    c_day = c_hr  && (day == 9'd511);

    sec_n   = tick  ? (c_sec ? 6'd0 : sec + 6'd1) : sec;
    min_n   = c_sec ? (c_min ? 6'd0 : min + 6'd1) : min;
    hr_n    = c_min ? (c_hr  ? 5'd0 : hr  + 5'd1) : hr;
    day_n   = c_hr  ? day + 9'd1 : day;
    carry_n = carry | c_day;
    halt_n  = halt;
    presc_n = halt ? presc : (tick ? '0 : presc + PW'(1));

    if (wr_evt && wr_reg == 3'b101 && ena) begin
      case (bank_sel)
        4'h8: begin
          sec_n   = bus.data_in[5:0];
          presc_n = '0;
        end
        4'h9: min_n = bus.data_in[5:0];
        4'hA: hr_n  = bus.data_in[4:0];
        4'hB: day_n[7:0] = bus.data_in;
        4'hC: begin
          carry_n  = bus.data_in[7];
          halt_n   = bus.data_in[6];
          day_n[8] = bus.data_in[0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_state <= IDLE;
    end else begin
      seq_state <= seq_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_q  <= 1'b0;
      ena      <= 1'b0;
      rom_bank <= '0;
      bank_sel <= '0;
      presc    <= '0;
      sec      <= '0;
      min      <= '0;
      hr       <= '0;
      day      <= '0;
      halt     <= 1'b0;
      carry    <= 1'b0;
      l_sec    <= '0;
      l_min    <= '0;
      l_hr     <= '0;
      l_day    <= '0;
      l_halt   <= 1'b0;
      l_carry  <= 1'b0;
    end else begin
      write_q <= bus.write;
      if (wr_evt && wr_reg == 3'b000) ena      <= (bus.data_in[3:0] == 4'hA);
      if (wr_evt && wr_reg == 3'b001) rom_bank <= bus.data_in[ROM_BANK_BITS-1:0];
      if (wr_evt && wr_reg == 3'b010) bank_sel <= bus.data_in[3:0];
      presc <= presc_n;
      sec   <= sec_n;
      min   <= min_n;
      hr    <= hr_n;
      day   <= day_n;
      halt  <= halt_n;
      carry <= carry_n;
      if (latch_now) begin
        l_sec   <= sec;
        l_min   <= min;
        l_hr    <= hr;
        l_day   <= day;
        l_halt  <= halt;
        l_carry <= carry;
      end
    end
  end

  // Combinational decode
  logic                     ram_win, rtc_idx, ram_idx;
  logic [ROM_BANK_BITS-1:0] rom_hi;

  always_comb begin
    ram_win = (bus.iadr[15:13] == 3'b101);
    rtc_idx = (bank_sel >= 4'h8) && (bank_sel <= 4'hC);
    ram_idx = (int'(bank_sel) < (1 << RAM_BANK_BITS));

    if (!bus.iadr[14])          rom_hi = '0;
    else if (rom_bank == '0)    rom_hi = ROM_BANK_BITS'(1);
    else                        rom_hi = rom_bank;

    bus.rom_adr = {rom_hi, bus.iadr[13:0]};
    bus.ram_adr = {bank_sel[RAM_BANK_BITS-1:0], bus.iadr[12:0]};
    bus.sel_rom = !reset && !bus.iadr[15];
    bus.sel_ram = !reset && ram_win && ena && ram_idx;
    bus.data_oe = !reset && ram_win && rtc_idx && ena && !bus.write;

    bus.data_out = 8'h00;
    if (ram_win) begin
      case (bank_sel)
        4'h8: bus.data_out = {2'b00, l_sec};
        4'h9: bus.data_out = {2'b00, l_min};
        4'hA: bus.data_out = {3'b000, l_hr};
        4'hB: bus.data_out = l_day[7:0];
        4'hC: bus.data_out = {l_carry, l_halt, 5'b00000, l_day[8]};
        default: bus.data_out = 8'h00;
      endcase
    end
  end
endmodule
